// File: rtl/alu_acc_seq_if.sv
// Control-unit <-> ALU handshake bundle: request (start/op/data_in) and registered result.
interface alu_acc_seq_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] data_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] acc_out;
   logic [3:0]       flags;

   modport master (output start, op, data_in, input busy, done, acc_out, flags);
   modport slave  (input start, op, data_in, output busy, done, acc_out, flags);
endinterface

// File: rtl/alu_acc_seq.sv
// Sequential accumulator ALU: single-cycle ops via EXEC, iterative shift-add MUL.
// ACC and FLAGS {N,V,C,Z} change only on the DONE cycle.
module alu_acc_seq #(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   alu_acc_seq_if.slave  io_bus
);
   localparam int MSB = WIDTH - 1;
   localparam int CW  = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

   localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_NOT = 4'h4,
                          OP_OR  = 4'h5, OP_XOR = 4'h6, OP_LD  = 4'h7, OP_ADC = 4'h8,
                          OP_SBB = 4'h9, OP_SHL = 4'hA, OP_SHR = 4'hB, OP_MUL = 4'hC;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

   state_t             r_state, w_state_nxt;
   logic               w_accept;
   logic [3:0]         r_op;
   logic [WIDTH-1:0]   r_opb;
   logic [WIDTH-1:0]   r_acc;
   logic [3:0]         r_flags;
   logic               r_done;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_prod;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;

   logic [WIDTH:0]     w_sum;
   logic [WIDTH-1:0]   w_res;
   logic               w_c, w_v, w_upd;
   logic               w_cin;
   logic               w_hi;

   assign w_cin = r_flags[1];
   assign w_hi  = |r_prod[2*WIDTH-1:WIDTH];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (io_bus.start) begin
               w_accept    = 1'b1;
               w_state_nxt = (io_bus.op == OP_MUL && MUL_EN) ? S_MUL : S_EXEC;
            end
         end
         S_EXEC:  w_state_nxt = S_IDLE;
         S_MUL:   if (r_cnt == CNT_LAST) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Single-cycle datapath; arithmetic runs at WIDTH+1 bits so the top bit is carry/borrow.
   always_comb begin
      w_sum = '0;
      w_res = r_acc;
      w_c   = 1'b0;
      w_v   = 1'b0;
      w_upd = 1'b1;
      case (r_op)
         OP_ADD, OP_ADC: begin
            w_sum = {1'b0, r_acc} + {1'b0, r_opb} + {{WIDTH{1'b0}}, (r_op == OP_ADC) & w_cin};
            w_res = w_sum[MSB:0];
            w_c   = w_sum[WIDTH];
            w_v   = (r_acc[MSB] == r_opb[MSB]) && (w_sum[MSB] != r_acc[MSB]);
         end
         OP_SUB, OP_SBB: begin
            w_sum = {1'b0, r_acc} - {1'b0, r_opb} - {{WIDTH{1'b0}}, (r_op == OP_SBB) & w_cin};
            w_res = w_sum[MSB:0];
            w_c   = w_sum[WIDTH];
            w_v   = (r_acc[MSB] != r_opb[MSB]) && (w_sum[MSB] != r_acc[MSB]);
         end
         OP_AND: w_res = r_acc & r_opb;
         OP_NOT: w_res = ~r_acc;
         OP_OR:  w_res = r_acc | r_opb;
         OP_XOR: w_res = r_acc ^ r_opb;
         OP_LD:  w_res = r_opb;
         OP_SHL: begin
            w_res = {r_acc[MSB-1:0], 1'b0};
            w_c   = r_acc[MSB];
         end
         OP_SHR: begin
            w_res = {1'b0, r_acc[MSB:1]};
            w_c   = r_acc[0];
         end
         // NOP, reserved codes, and MUL when the multiplier is not built
         default: w_upd = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_op     <= '0;
         r_opb    <= '0;
         r_acc    <= '0;
         r_flags  <= '0;
         r_done   <= 1'b0;
         r_cnt    <= '0;
         r_prod   <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_op     <= io_bus.op;
            r_opb    <= io_bus.data_in;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, r_acc};
            r_mplier <= io_bus.data_in;
         end
         if (r_state == S_EXEC) begin
            r_done <= 1'b1;
            if (w_upd) begin
               r_acc   <= w_res;
               r_flags <= {w_res[MSB], w_v, w_c, w_res == '0};
            end
         end
         // WIDTH shift-add steps, then one commit cycle so ACC never shows a partial product
         if (r_state == S_MUL) begin
            if (r_cnt == CNT_LAST) begin
               r_done  <= 1'b1;
               r_acc   <= r_prod[MSB:0];
               r_flags <= {r_prod[MSB], w_hi, w_hi, r_prod[MSB:0] == '0};
            end else begin
               if (r_mplier[0]) r_prod <= r_prod + r_mcand;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
            end
         end
      end
   end

   assign io_bus.busy    = (r_state != S_IDLE);
   assign io_bus.done    = r_done;
   assign io_bus.acc_out = r_acc;
   assign io_bus.flags   = r_flags;
endmodule

// File: tb/tb_alu_acc_seq.sv
// Bench for alu_acc_seq: integer-arithmetic reference model, per-cycle compare, directed + random stimulus.
module tb_alu_acc_seq;
   localparam int W = 8;
   localparam int M = 1 << W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_acc_seq_if #(.WIDTH(W)) bus ();
   alu_acc_seq_if #(.WIDTH(W)) bus0 ();

   alu_acc_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut  (.i_clk(clk), .i_rst(rst), .io_bus(bus));
   alu_acc_seq #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (.i_clk(clk), .i_rst(rst), .io_bus(bus0));

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference: what an op does to (ACC, FLAGS), from plain integer arithmetic.
   function automatic void model_op(input int op, input int d, input int a, input logic [3:0] f,
                                    output int r, output logic [3:0] nf);
      int s, sa, sd, sr, c, v, cc, p;
      c  = f[1];
      sa = (a >= M/2) ? a - M : a;
      sd = (d >= M/2) ? d - M : d;
      v  = 0;
      cc = 0;
      s  = 0;
      case (op)
         1, 8: begin
            s  = a + d + ((op == 8) ? c : 0);
            sr = sa + sd + ((op == 8) ? c : 0);
            cc = (s >= M);
            v  = (sr > M/2 - 1 || sr < -M/2);
         end
         2, 9: begin
            s  = a - d - ((op == 9) ? c : 0);
            sr = sa - sd - ((op == 9) ? c : 0);
            cc = (s < 0);
            v  = (sr > M/2 - 1 || sr < -M/2);
         end
         3:  s = a & d;
         4:  s = M - 1 - a;
         5:  s = a | d;
         6:  s = a ^ d;
         7:  s = d;
         10: begin s = a * 2; cc = (a >= M/2); end
         11: begin s = a / 2; cc = a % 2; end
         12: begin p = a * d; s = p; cc = (p / M) != 0; v = cc; end
         default: begin r = a; nf = f; return; end
      endcase
      r  = ((s % M) + M) % M;
      nf = {r >= M/2, v[0], cc[0], r == 0};
   endfunction

   int         m_acc, p_acc, m_rem;
   logic [3:0] m_fl, p_fl;
   logic       m_done;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_acc = 0; m_fl = '0; m_rem = 0; m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
               m_acc  = p_acc;
               m_fl   = p_fl;
               m_done = 1'b1;
            end
         end else if (bus.start) begin
            model_op(int'(bus.op), int'(bus.data_in), m_acc, m_fl, p_acc, p_fl);
            m_rem = (bus.op == 4'hC) ? W + 1 : 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && chk_en) begin
         chk("busy",  int'(bus.busy),    int'(m_rem > 0));
         chk("done",  int'(bus.done),    int'(m_done));
         chk("acc",   int'(bus.acc_out), m_acc);
         chk("flags", int'(bus.flags),   int'(m_fl));
      end
   end

   // Issue one op and measure samples until DONE; optionally poke an ADD 0x01 while busy.
   task automatic do_op(input logic [3:0] op, input logic [7:0] d, input bit inj,
                        output int lat, output int bcnt);
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.data_in = d;
      @(negedge clk);
      bus.start = 1'b0; bus.data_in = 8'($urandom);
      lat = 0; bcnt = 0;
      while (!bus.done) begin
         if (lat > W + 3) begin
            chk("done_timeout", 0, 1);
            break;
         end
         if (bus.busy) bcnt++;
         if (inj && lat == 3) begin bus.start = 1'b1; bus.op = 4'h1; bus.data_in = 8'h01; end
         if (inj && lat == 4) bus.start = 1'b0;
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bcnt, seen;
      bus.start = 1'b0;  bus.op = '0;  bus.data_in = '0;
      bus0.start = 1'b0; bus0.op = '0; bus0.data_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_acc",   int'(bus.acc_out), 0);
      chk("rst_flags", int'(bus.flags),   0);
      chk("rst_busy",  int'(bus.busy),    0);
      chk("rst_done",  int'(bus.done),    0);
      rst = 1'b0;
      chk_en = 1'b1;

      do_op(4'h7, 8'hFF, 0, lat, bcnt);
      do_op(4'h1, 8'h01, 0, lat, bcnt);
      chk("add_lat",   lat, 1);
      chk("add_acc",   int'(bus.acc_out), 'h00);
      chk("add_flags", int'(bus.flags),   'b0011);

      do_op(4'h7, 8'h7F, 0, lat, bcnt);
      do_op(4'h1, 8'h01, 0, lat, bcnt);
      chk("ovf_acc",   int'(bus.acc_out), 'h80);
      chk("ovf_flags", int'(bus.flags),   'b1100);
      do_op(4'h9, 8'h80, 0, lat, bcnt);
      chk("sbb_acc",   int'(bus.acc_out), 'h00);
      chk("sbb_flags", int'(bus.flags),   'b0001);

      do_op(4'h7, 8'h10, 0, lat, bcnt);
      do_op(4'hC, 8'h20, 1, lat, bcnt);
      chk("mul_lat",   lat,  9);
      chk("mul_busy",  bcnt, 9);
      chk("mul_acc",   int'(bus.acc_out), 'h00);
      chk("mul_flags", int'(bus.flags),   'b0111);
      @(negedge clk);
      chk("mul_one_done", int'(bus.done), 0);
      chk("mul_ign_acc",  int'(bus.acc_out), 'h00);

      do_op(4'h7, 8'hF0, 0, lat, bcnt);
      do_op(4'h1, 8'h20, 0, lat, bcnt);
      do_op(4'hE, 8'h55, 0, lat, bcnt);
      chk("rsv_lat",   lat, 1);
      chk("rsv_acc",   int'(bus.acc_out), 'h10);
      chk("rsv_flags", int'(bus.flags),   'b0010);
      do_op(4'h0, 8'hAA, 0, lat, bcnt);
      chk("nop_lat",   lat, 1);
      chk("nop_acc",   int'(bus.acc_out), 'h10);
      chk("nop_flags", int'(bus.flags),   'b0010);

      do_op(4'h7, 8'h03, 0, lat, bcnt);
      @(negedge clk);
      bus.start = 1'b1; bus.op = 4'hC; bus.data_in = 8'h05;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mrst_busy",  int'(bus.busy),    0);
      chk("mrst_acc",   int'(bus.acc_out), 0);
      chk("mrst_flags", int'(bus.flags),   0);
      chk("mrst_done",  int'(bus.done),    0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (W + 3) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      chk("mrst_no_done", seen, 0);

      repeat (3000) begin
         @(negedge clk);
         bus.start   = ($urandom_range(2) == 0);
         bus.op      = 4'($urandom);
         bus.data_in = 8'($urandom);
      end
      @(negedge clk);
      bus.start = 1'b0;
      repeat (W + 4) @(negedge clk);

      @(negedge clk);
      bus0.start = 1'b1; bus0.op = 4'h7; bus0.data_in = 8'h85;
      @(negedge clk);
      bus0.start = 1'b0;
      @(negedge clk);
      chk("nm_ld_done", int'(bus0.done),    1);
      chk("nm_ld_acc",  int'(bus0.acc_out), 'h85);
      bus0.start = 1'b1; bus0.op = 4'hC; bus0.data_in = 8'h03;
      @(negedge clk);
      bus0.start = 1'b0;
      chk("nm_mul_busy", int'(bus0.busy), 1);
      @(negedge clk);
      chk("nm_mul_done",  int'(bus0.done),    1);
      chk("nm_mul_acc",   int'(bus0.acc_out), 'h85);
      chk("nm_mul_flags", int'(bus0.flags),   'b1000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
